// File: rtl/ps2_key_ctrl_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl_decoder_if
// Raw key-event stream from the PS/2 control decoder to a debug/OSD consumer.
//   ev_data     {pressed, extended, scancode} at the queue head
//   ev_valid    queue non-empty
//   ev_ready    consumer pops the head when ev_valid && ev_ready
//   ev_overflow sticky: an event was dropped because the queue was full
// master: the decoder (producer); slave: the consumer.
// ---------------------------------------------------------------------------
interface ps2_key_ctrl_decoder_if;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_overflow;

    modport master (
        output ev_data,
        output ev_valid,
        output ev_overflow,
        input  ev_ready
    );

    modport slave (
        input  ev_data,
        input  ev_valid,
        input  ev_overflow,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl_decoder
// Decodes the hps_io ps2_key event word into held arcade controls, stretches
// coin presses into a coin pulse and, optionally, queues raw key events.
//
// Optional feature macro: PS2_KEY_EVENT_FIFO_EN
//   defined   : every detected event is queued in a FIFO_DEPTH-entry FIFO
//   undefined : no queue; ev_data/ev_valid/ev_overflow tied low, ev_ready ignored
//
// Ports
//   clk_sys     in   system clock, all registers on its rising edge
//   reset_n     in   asynchronous active-low reset
//   ps2_key     in   [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   clear       in   synchronous release of all held controls and coin pulse
//   ctrl        out  0 up, 1 down, 2 left, 3 right, 4 fire1, 5 fire2,
//                    6 coin, 7 start1, 8 start2
//   coin_pulse  out  high for COIN_PULSE_CYCLES after a coin press
//   ev          if   raw event stream (master modport)
// ---------------------------------------------------------------------------
module ps2_key_ctrl_decoder #(
    parameter logic [15:0] COIN_PULSE_CYCLES = 16'd48000,
    parameter int          FIFO_DEPTH        = 8
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [10:0]                   ps2_key,
    input  logic                          clear,
    output logic [8:0]                    ctrl,
    output logic                          coin_pulse,
    ps2_key_ctrl_decoder_if.master        ev
);

    // state    | meaning
    // ST_PRIME | first edge after reset: adopt current toggle level, no event
    // ST_RUN   | normal operation: toggle change strobes one event
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Internal held-bit indices; fire1 has two physical sources.
    localparam int H_UP     = 0;
    localparam int H_DOWN   = 1;
    localparam int H_LEFT   = 2;
    localparam int H_RIGHT  = 3;
    localparam int H_LCTRL  = 4;
    localparam int H_SPACE  = 5;
    localparam int H_FIRE2  = 6;
    localparam int H_COIN   = 7;
    localparam int H_START1 = 8;
    localparam int H_START2 = 9;

    state_t      state_q, state_d;
    logic [10:0] key_q;
    logic        tog_q, tog_d;
    logic        ev_stb;
    logic [9:0]  held_q, held_d;
    logic [15:0] coin_cnt_q, coin_cnt_d;
    logic        coin_press;

    // key_q has no reset so that, as long as clk_sys runs during reset, the
    // priming edge sees the live toggle level rather than a reset constant.
    always_ff @(posedge clk_sys) begin
        key_q <= ps2_key;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_PRIME;
            tog_q      <= 1'b0;
            held_q     <= '0;
            coin_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tog_q      <= tog_d;
            held_q     <= held_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tog_d   = tog_q;
        ev_stb  = 1'b0;
        case (state_q)
            ST_PRIME: begin
                state_d = ST_RUN;
                tog_d   = key_q[10];
            end
            ST_RUN: begin
                // tog_q follows regardless of clear so no event is ever lost
                if (key_q[10] != tog_q) begin
                    ev_stb = 1'b1;
                    tog_d  = key_q[10];
                end
            end
            default: state_d = ST_PRIME;
        endcase
    end

    always_comb begin
        held_d     = held_q;
        coin_press = 1'b0;
        if (ev_stb) begin
            case (key_q[8:0])
                9'h175: held_d[H_UP]     = key_q[9];
                9'h172: held_d[H_DOWN]   = key_q[9];
                9'h16B: held_d[H_LEFT]   = key_q[9];
                9'h174: held_d[H_RIGHT]  = key_q[9];
                9'h014: held_d[H_LCTRL]  = key_q[9];
                9'h011: held_d[H_FIRE2]  = key_q[9];
                9'h029: held_d[H_SPACE]  = key_q[9];
                9'h02E: begin
                    held_d[H_COIN] = key_q[9];
                    coin_press     = key_q[9];
                end
                9'h016: held_d[H_START1] = key_q[9];
                9'h01E: held_d[H_START2] = key_q[9];
                default: ;
            endcase
        end
        if (clear) begin
            held_d = '0;
        end
    end

    // Coin release never touches the counter; a repeated press restarts it.
    always_comb begin
        coin_cnt_d = coin_cnt_q;
        if (clear) begin
            coin_cnt_d = '0;
        end else if (coin_press) begin
            coin_cnt_d = COIN_PULSE_CYCLES;
        end else if (coin_cnt_q != 16'd0) begin
            coin_cnt_d = coin_cnt_q - 16'd1;
        end
    end

    assign coin_pulse = (coin_cnt_q != 16'd0);
    assign ctrl = {held_q[H_START2], held_q[H_START1], held_q[H_COIN],
                   held_q[H_FIRE2], held_q[H_LCTRL] | held_q[H_SPACE],
                   held_q[H_RIGHT], held_q[H_LEFT], held_q[H_DOWN],
                   held_q[H_UP]};

`ifdef PS2_KEY_EVENT_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   fcnt_q, fcnt_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, push, pop;

    assign empty = (fcnt_q == '0);
    assign full  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = ev.ev_ready && !empty;
    // A simultaneous pop frees a slot, so a full queue can still accept.
    assign push  = ev_stb && (!full || pop);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        fcnt_d = fcnt_q;
        ovf_d  = ovf_q;
        if (push) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + (AW+1)'(1);
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - (AW+1)'(1);
        end
        if (ev_stb && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fcnt_q <= fcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_q] <= key_q[9:0];
        end
    end

    // Head is driven from registers only; masked to zero while empty.
    assign ev.ev_data     = empty ? 10'h000 : mem_q[rd_q];
    assign ev.ev_valid    = !empty;
    assign ev.ev_overflow = ovf_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, ev.ev_ready, FIFO_DEPTH[0]};

    assign ev.ev_data     = 10'h000;
    assign ev.ev_valid    = 1'b0;
    assign ev.ev_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_ctrl_decoder
// Directed bench for ps2_key_ctrl_decoder with COIN_PULSE_CYCLES=4 and
// FIFO_DEPTH=2. Queue checks are active when PS2_KEY_EVENT_FIFO_EN is defined.
// ---------------------------------------------------------------------------
module tb_ps2_key_ctrl_decoder;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        clear;
    logic [8:0]  ctrl;
    logic        coin_pulse;
    logic        tog;
    int          vectors     = 0;
    int          miscompares = 0;
    int          hi;

    ps2_key_ctrl_decoder_if ev ();

    ps2_key_ctrl_decoder #(
        .COIN_PULSE_CYCLES (16'd4),
        .FIFO_DEPTH        (2)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .clear      (clear),
        .ctrl       (ctrl),
        .coin_pulse (coin_pulse),
        .ev         (ev.master)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    initial begin
        reset_n     = 1'b0;
        ps2_key     = 11'h400;
        tog         = 1'b1;
        clear       = 1'b0;
        ev.ev_ready = 1'b0;
        repeat (3) tick();
        chk("rst_ctrl", 32'(ctrl), 32'h0);
        chk("rst_coin", 32'(coin_pulse), 32'h0);
        reset_n = 1'b1;
        repeat (10) tick();
        chk("prime_ctrl", 32'(ctrl), 32'h0);
        chk("prime_valid", 32'(ev.ev_valid), 32'h0);
        chk("prime_data", 32'(ev.ev_data), 32'h0);
        chk("prime_ovf", 32'(ev.ev_overflow), 32'h0);

        // up press / release
        send(1'b1, 1'b1, 8'h75);
        tick();
        chk("up_lat1", 32'(ctrl), 32'h000);
        chk("up_valid_early", 32'(ev.ev_valid), 32'h0);
        tick();
        chk("up_press", 32'(ctrl), 32'h001);
        send(1'b0, 1'b1, 8'h75);
        tick();
        chk("up_hold", 32'(ctrl), 32'h001);
        tick();
        chk("up_release", 32'(ctrl), 32'h000);
`ifdef PS2_KEY_EVENT_FIFO_EN
        chk("fifo_head0", 32'(ev.ev_data), 32'h375);
        chk("fifo_valid0", 32'(ev.ev_valid), 32'h1);
        ev.ev_ready = 1'b1;
        tick();
        chk("fifo_head1", 32'(ev.ev_data), 32'h175);
        tick();
        chk("fifo_empty", 32'(ev.ev_valid), 32'h0);
`else
        chk("tied_valid", 32'(ev.ev_valid), 32'h0);
        chk("tied_data", 32'(ev.ev_data), 32'h0);
        ev.ev_ready = 1'b1;
`endif

        // fire1 aliases
        send(1'b1, 1'b0, 8'h14); tick(); tick();
        chk("lctrl_press", 32'(ctrl), 32'h010);
        send(1'b1, 1'b0, 8'h29); tick(); tick();
        chk("space_press", 32'(ctrl), 32'h010);
        send(1'b0, 1'b0, 8'h14); tick(); tick();
        chk("lctrl_rel_alias", 32'(ctrl), 32'h010);
        send(1'b0, 1'b0, 8'h29); tick(); tick();
        chk("space_rel", 32'(ctrl), 32'h000);
        send(1'b1, 1'b0, 8'h11); tick(); tick();
        chk("fire2_press", 32'(ctrl), 32'h020);
        send(1'b0, 1'b0, 8'h11); tick(); tick();

        // unmapped codes, including extended variant of a mapped code
        send(1'b1, 1'b0, 8'h1C); tick(); tick();
        chk("unmapped_a", 32'(ctrl), 32'h000);
        send(1'b1, 1'b1, 8'h14); tick(); tick();
        chk("unmapped_e014", 32'(ctrl), 32'h000);
        send(1'b1, 1'b1, 8'h6B); tick(); tick();
        chk("left_press", 32'(ctrl), 32'h004);
        send(1'b0, 1'b1, 8'h6B); tick(); tick();

        // coin: press, re-press two cycles later
        send(1'b1, 1'b0, 8'h2E);
        tick();
        chk("coin_lat1", 32'(coin_pulse), 32'h0);
        tick();
        chk("coin_ctrl", 32'(ctrl), 32'h040);
        hi = int'(coin_pulse);
        send(1'b1, 1'b0, 8'h2E);
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(coin_pulse);
        end
        chk("coin_len", 32'(hi), 32'd6);
        chk("coin_held", 32'(ctrl), 32'h040);
        send(1'b0, 1'b0, 8'h2E); tick(); tick();
        chk("coin_release", 32'(ctrl), 32'h000);

        // coin release does not cut the pulse
        send(1'b1, 1'b0, 8'h2E); tick(); tick();
        send(1'b0, 1'b0, 8'h2E); tick(); tick();
        chk("coin_rel_ctrl", 32'(ctrl), 32'h000);
        chk("coin_rel_pulse", 32'(coin_pulse), 32'h1);
        tick(); tick();
        chk("coin_rel_end", 32'(coin_pulse), 32'h0);

        // clear in the same cycle as a start1 press
        send(1'b1, 1'b1, 8'h75); tick(); tick();
        send(1'b1, 1'b0, 8'h14); tick(); tick();
        chk("upfire_held", 32'(ctrl), 32'h011);
        send(1'b1, 1'b0, 8'h16);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_ctrl", 32'(ctrl), 32'h000);
`ifdef PS2_KEY_EVENT_FIFO_EN
        chk("clear_push_valid", 32'(ev.ev_valid), 32'h1);
        chk("clear_push_data", 32'(ev.ev_data), 32'h216);
`endif
        tick();
        chk("clear_tog_kept", 32'(ctrl), 32'h000);
        send(1'b1, 1'b0, 8'h1E); tick(); tick();
        chk("start2_press", 32'(ctrl), 32'h100);

        // clear kills an active coin pulse
        send(1'b1, 1'b0, 8'h2E); tick(); tick();
        chk("coin_before_clr", 32'(coin_pulse), 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("coin_clr_pulse", 32'(coin_pulse), 32'h0);
        chk("coin_clr_ctrl", 32'(ctrl), 32'h000);

`ifdef PS2_KEY_EVENT_FIFO_EN
        // overflow with depth 2, then pop+push on full
        tick();
        chk("ovf_pre_empty", 32'(ev.ev_valid), 32'h0);
        ev.ev_ready = 1'b0;
        send(1'b1, 1'b0, 8'h1C); tick(); tick();
        send(1'b0, 1'b0, 8'h1C); tick(); tick();
        chk("full_no_ovf", 32'(ev.ev_overflow), 32'h0);
        send(1'b1, 1'b0, 8'h32); tick(); tick();
        chk("ovf_set", 32'(ev.ev_overflow), 32'h1);
        chk("ovf_head", 32'(ev.ev_data), 32'h21C);
        send(1'b0, 1'b0, 8'h32);
        tick();
        ev.ev_ready = 1'b1;
        tick();
        ev.ev_ready = 1'b0;
        chk("poppush_ovf", 32'(ev.ev_overflow), 32'h1);
        chk("poppush_head", 32'(ev.ev_data), 32'h01C);
        tick();
        chk("poppush_stall", 32'(ev.ev_data), 32'h01C);
        ev.ev_ready = 1'b1;
        tick();
        chk("poppush_second", 32'(ev.ev_data), 32'h032);
        tick();
        chk("poppush_empty", 32'(ev.ev_valid), 32'h0);
        chk("ovf_sticky", 32'(ev.ev_overflow), 32'h1);
`else
        chk("tied_ovf", 32'(ev.ev_overflow), 32'h0);
        chk("tied_valid_end", 32'(ev.ev_valid), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
